xor_crc_engine: RTL and testbench
=================================

// Module: xor_crc_engine
// PURPOSE
//  Parametrised CRC/LFSR accumulator built from 74x86-class XOR cells and 74x273-class D registers.
//  Consumes DW-bit beats over a valid/ready handshake and folds them MSB-first into a W-bit CRC.
//  Presents the finished CRC, final-XORed, through an output handshake.
//  Sits between a byte/word source and a frame checker; it is the sequential successor to the 2-bit XOR map.
// PARAMETERS
//  W       8     CRC register width, 2..32
//  DW      8     data bits consumed per accepted beat, 1..W
//  POLY    8'h07 generator polynomial, W bits, implicit x^W term
//  INIT    '0    seed loaded at frame start, W bits
//  XOROUT  '0    value XORed into CRC_OUT at completion, W bits
//  CW      16    beat counter width
// PORTS
//  CLK        in   1   rising-edge clock
//  RST        in   1   asynchronous, active-high reset
//  CLEAR      in   1   synchronous abort; returns to IDLE
//  IN_DATA    in   DW  data beat, MSB processed first
//  IN_VALID   in   1   beat present
//  IN_LAST    in   1   beat is the final beat of the frame
//  IN_READY   out  1   engine accepts a beat this cycle
//  CRC_OUT    out  W   finished CRC (after XOROUT)
//  CRC_VALID  out  1   CRC_OUT valid
//  OUT_READY  in   1   consumer takes CRC_OUT
//  BEAT_CNT   out  CW  beats accepted in the current/last frame, saturating
// BEHAVIOUR
//  - Reset (async): state=IDLE, crc_q=INIT, CRC_OUT=0, CRC_VALID=0, BEAT_CNT=0. IN_READY=1 once RST deasserts.
//  - Beat accepted when IN_VALID & IN_READY & ~CLEAR.
//  - Step function, per data bit i = DW-1..0:
//    fb = c[W-1]^d[i]; c = c<<1 (drop MSB); if fb then c ^= POLY. All arithmetic is mod 2, W bits.
//  - States:
//    IDLE:  IN_READY=1. Accepted beat: crc_q=step(INIT,IN_DATA); BEAT_CNT=1.
//           Next state ACCUM, or DONE if IN_LAST.
//    ACCUM: IN_READY=1. Accepted beat: crc_q=step(crc_q,IN_DATA); BEAT_CNT+1, saturating at 2^CW-1.
//           IN_LAST -> DONE.
//    DONE:  IN_READY=0; CRC_VALID=1; CRC_OUT is held stable.
//           OUT_READY=1 -> IDLE next cycle; CRC_VALID falls; crc_q=INIT.
//  - Entry to DONE: CRC_OUT registered as step(prev,IN_DATA)^XOROUT in the same edge.
//    Latency is 1 cycle from the last-beat edge to CRC_VALID=1.
//  - BEAT_CNT holds its value through DONE and IDLE. It restarts at 1 on the first beat of the next frame.
//  - CLEAR (any state) wins over every other event: beat dropped, CRC_VALID=0, state=IDLE, crc_q=INIT.
//    BEAT_CNT=0. CRC_OUT is not cleared.
//  - IN_READY is a function of state and CLEAR only (=0 while CLEAR); there is no combinational path from IN_VALID.
//  - IN_VALID with IN_READY=0 (DONE): beat is not consumed; the source holds it.
//  - Zero-length frame is not representable; single-beat frames (IN_LAST on the first beat) are legal.
//  - Async RST mid-frame: immediate return to reset values; the partial frame is lost.
//  - IN_DATA and IN_LAST are ignored when not accepted.
// STRUCTURE
//  - Shared package xor_crc_pkg:
//    typedef of the state enum {IDLE, ACCUM, DONE}.
//    Standard polynomial constants: CRC8_POLY=8'h07, CRC16_CCITT_POLY=16'h1021, CRC32_POLY=32'h04C11DB7.
//  - One sub-module xor_crc_step: purely combinational DW-bit unrolled XOR network (W,DW,POLY params).
//    It maps onto 74x86 XOR cells via techmap.
//  - Top: FSM, crc_q / CRC_OUT / BEAT_CNT registers (74x273/574-class), handshake logic.
// TESTING
//  1. W=8,POLY=07,INIT=0; beats 0x31..0x39 with IN_LAST on 0x39
//     -> CRC_OUT=0xF4, CRC_VALID 1 cycle later, BEAT_CNT=9.
//  2. W=16,POLY=1021,INIT=FFFF,DW=8; "123456789"
//     -> CRC_OUT=0x29B1; hold OUT_READY=0 5 cycles -> CRC_OUT/CRC_VALID stable, IN_READY=0.
//  3. Back-to-back frames, OUT_READY=1 on the first CRC_VALID cycle; second frame single beat 0x00, CRC-8
//     -> second CRC_OUT=0x00, BEAT_CNT=1, no bubble beyond one DONE cycle.
//  4. CLEAR asserted with IN_VALID on beat 4 of 9; then restart the full frame
//     -> beat dropped, state IDLE, final CRC_OUT=0xF4 (CRC-8 case).
//  5. RST pulsed asynchronously (mid-cycle) during ACCUM
//     -> outputs at reset values before the next CLK edge; the next frame computes correctly.
//  6. CW=4; 20-beat frame -> BEAT_CNT saturates at 15; CRC still matches the reference model.

Source files
------------

// File: rtl/xor_crc_pkg.sv
// ---------------------------------------------------------------------------
// xor_crc_pkg
//   Shared definitions for the XOR/LFSR CRC engine:
//   - state_t: engine sequencing states (IDLE, ACCUM, DONE)
//   - standard generator polynomials. The x^W term is implicit, so only the
//     lower W bits are stored.
// ---------------------------------------------------------------------------
package xor_crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

endpackage

// File: rtl/xor_crc_engine_if.sv
// ---------------------------------------------------------------------------
// xor_crc_engine_if
//   Bundles the beat input handshake, the CRC output handshake, the
//   synchronous abort and the beat counter of the CRC engine.
//   Modports:
//     master - data source / CRC consumer (drives clear, in_*, out_ready)
//     slave  - the CRC engine (drives in_ready, crc_out, crc_valid, beat_cnt)
//   Parameters: W (CRC width), DW (beat width), CW (beat counter width).
// ---------------------------------------------------------------------------
interface xor_crc_engine_if #(
  parameter int W  = 8,
  parameter int DW = 8,
  parameter int CW = 16
) ();

  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  crc_out;
  logic          crc_valid;
  logic          out_ready;
  logic [CW-1:0] beat_cnt;

  modport master (
    output clear, in_data, in_valid, in_last, out_ready,
    input  in_ready, crc_out, crc_valid, beat_cnt
  );

  modport slave (
    input  clear, in_data, in_valid, in_last, out_ready,
    output in_ready, crc_out, crc_valid, beat_cnt
  );

endinterface

// File: rtl/xor_crc_step.sv
// ---------------------------------------------------------------------------
// xor_crc_step
//   Purely combinational DW-bit unrolled CRC step: folds data into crc_in
//   MSB first, one LFSR shift per data bit. Synthesises to a flat XOR
//   network.
//   Ports:
//     crc_in  [W-1:0]  running CRC before this beat
//     data    [DW-1:0] beat, bit DW-1 is consumed first
//     crc_out [W-1:0]  running CRC after this beat
//   Parameters: W, DW, POLY (W bits, implicit x^W term).
// ---------------------------------------------------------------------------
module xor_crc_step
  import xor_crc_pkg::*;
#(
  parameter int           W    = 8,
  parameter int           DW   = 8,
  parameter logic [W-1:0] POLY = CRC8_POLY
) (
  input  logic [W-1:0]  crc_in,
  input  logic [DW-1:0] data,
  output logic [W-1:0]  crc_out
);

  logic [W-1:0] c;
  logic         fb;

  // The loop is fully unrolled at elaboration; each iteration is one shift
  // plus a conditional XOR with the polynomial.
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[W-1] ^ data[i];
      c  = {c[W-2:0], 1'b0} ^ ({W{fb}} & POLY);
    end
    crc_out = c;
  end

endmodule

// File: rtl/xor_crc_engine.sv
// ---------------------------------------------------------------------------
// xor_crc_engine
//   Accepts DW-bit beats over a valid/ready handshake, folds them MSB first
//   into a W-bit CRC and presents the final-XORed result through an output
//   handshake.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - xor_crc_engine_if.slave:
//            clear     synchronous abort back to IDLE (wins over all else)
//            in_data / in_valid / in_last / in_ready   beat input handshake
//            crc_out / crc_valid / out_ready           result handshake
//            beat_cnt  beats accepted in the current/last frame, saturating
//   Parameters: W, DW, POLY, INIT, XOROUT, CW.
// ---------------------------------------------------------------------------
module xor_crc_engine
  import xor_crc_pkg::*;
#(
  parameter int           W      = 8,
  parameter int           DW     = 8,
  parameter logic [W-1:0] POLY   = CRC8_POLY,
  parameter logic [W-1:0] INIT   = '0,
  parameter logic [W-1:0] XOROUT = '0,
  parameter int           CW     = 16
) (
  input  logic           clk,
  input  logic           rst,
  xor_crc_engine_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_reg, state_next;
  logic [W-1:0]  crc_reg, crc_next;
  logic [W-1:0]  out_reg, out_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [W-1:0]  step_in, step_out;
  logic          accept;

  // The first beat of a frame always starts from INIT, so a stale crc_reg
  // can never leak into a new frame.
  assign step_in = (state_reg == IDLE) ? INIT : crc_reg;

  xor_crc_step #(
    .W    (W),
    .DW   (DW),
    .POLY (POLY)
  ) u_step (
    .crc_in  (step_in),
    .data    (bus.in_data),
    .crc_out (step_out)
  );

  // Ready depends only on state and clear, never on in_valid.
  assign bus.in_ready  = (state_reg != DONE) && !bus.clear;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.crc_valid = (state_reg == DONE);
  assign bus.crc_out   = out_reg;
  assign bus.beat_cnt  = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      crc_reg   <= INIT;
      out_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    out_next   = out_reg;
    cnt_next   = cnt_reg;

    if (bus.clear) begin
      // Abort: drop any beat, forget the partial CRC; crc_out is kept.
      state_next = IDLE;
      crc_next   = INIT;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            crc_next = step_out;
            if (state_reg == IDLE) begin
              cnt_next = {{(CW-1){1'b0}}, 1'b1};
            end else if (cnt_reg != CNT_MAX) begin
              cnt_next = cnt_reg + 1'b1;
            end
            if (bus.in_last) begin
              // Result is registered on the same edge as the last beat.
              state_next = DONE;
              out_next   = step_out ^ XOROUT;
            end else begin
              state_next = ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_next = IDLE;
            crc_next   = INIT;
          end
        end
        default: begin
          state_next = IDLE;
          crc_next   = INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_crc_engine.sv
// ---------------------------------------------------------------------------
// tb_xor_crc_engine
//   Two engines: A = CRC-8 (poly 07, init 00, CW=4),
//                B = CRC-16/CCITT (poly 1021, init FFFF, CW=16).
//   The reference model keeps each frame's beats and computes the CRC by
//   polynomial long division of the whole message; a negedge process checks
//   every output of both engines each cycle against it.
// ---------------------------------------------------------------------------
module tb_xor_crc_engine;
  import xor_crc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       drv_clear  [2];
  logic       drv_valid  [2];
  logic       drv_last   [2];
  logic       drv_oready [2];
  logic [7:0] drv_data   [2];

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_crc   [2];
  logic [31:0] o_cnt   [2];

  xor_crc_engine_if #(.W(8),  .DW(8), .CW(4))  bus_a ();
  xor_crc_engine_if #(.W(16), .DW(8), .CW(16)) bus_b ();

  assign bus_a.clear     = drv_clear[0];
  assign bus_a.in_valid  = drv_valid[0];
  assign bus_a.in_last   = drv_last[0];
  assign bus_a.in_data   = drv_data[0];
  assign bus_a.out_ready = drv_oready[0];
  assign bus_b.clear     = drv_clear[1];
  assign bus_b.in_valid  = drv_valid[1];
  assign bus_b.in_last   = drv_last[1];
  assign bus_b.in_data   = drv_data[1];
  assign bus_b.out_ready = drv_oready[1];

  assign o_ready[0] = bus_a.in_ready;
  assign o_valid[0] = bus_a.crc_valid;
  assign o_crc[0]   = {24'h0, bus_a.crc_out};
  assign o_cnt[0]   = {28'h0, bus_a.beat_cnt};
  assign o_ready[1] = bus_b.in_ready;
  assign o_valid[1] = bus_b.crc_valid;
  assign o_crc[1]   = {16'h0, bus_b.crc_out};
  assign o_cnt[1]   = {16'h0, bus_b.beat_cnt};

  xor_crc_engine #(
    .W(8), .DW(8), .POLY(CRC8_POLY), .INIT(8'h00), .XOROUT(8'h00), .CW(4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  xor_crc_engine #(
    .W(16), .DW(8), .POLY(CRC16_CCITT_POLY), .INIT(16'hFFFF), .XOROUT(16'h0000), .CW(16)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int w_of(input int k);
    return (k == 0) ? 8 : 16;
  endfunction
  function automatic logic [31:0] poly_of(input int k);
    return (k == 0) ? 32'h07 : 32'h1021;
  endfunction
  function automatic logic [31:0] init_of(input int k);
    return (k == 0) ? 32'h00 : 32'hFFFF;
  endfunction
  function automatic logic [31:0] xorout_of(input int k);
    return (k == 0) ? 32'h00 : 32'h0000;
  endfunction
  function automatic int unsigned cmax_of(input int k);
    return (k == 0) ? 15 : 65535;
  endfunction

  // Remainder of (INIT*x^len + M(x)*x^W) divided by the generator.
  function automatic logic [31:0] crc_ref(input int k, input logic [7:0] beats[$]);
    int          w    = w_of(k);
    logic [31:0] poly = poly_of(k);
    logic [31:0] init = init_of(k);
    bit          dv[$];
    int          len;
    logic [31:0] r;
    foreach (beats[b])
      for (int i = 7; i >= 0; i--) dv.push_back(beats[b][i]);
    len = dv.size();
    for (int t = 0; t < w; t++) dv.push_back(1'b0);
    for (int t = 0; t < w; t++) dv[t] ^= init[w-1-t];
    for (int j = 0; j < len; j++)
      if (dv[j])
        for (int t = 1; t <= w; t++) dv[j+t] ^= poly[w-t];
    r = '0;
    for (int t = 0; t < w; t++) r = {r[30:0], dv[len+t]};
    return r ^ xorout_of(k);
  endfunction

  bit          m_done [2];
  int unsigned m_cnt  [2];
  logic [31:0] m_out  [2];
  logic [7:0]  m_q0[$];
  logic [7:0]  m_q1[$];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] q[$];
      q = (k == 0) ? m_q0 : m_q1;
      if (rst) begin
        m_done[k] = 1'b0; m_cnt[k] = 0; m_out[k] = '0; q.delete();
      end else if (drv_clear[k]) begin
        m_done[k] = 1'b0; m_cnt[k] = 0; q.delete();
      end else if (m_done[k]) begin
        if (drv_oready[k]) m_done[k] = 1'b0;
      end else if (drv_valid[k]) begin
        q.push_back(drv_data[k]);
        if (q.size() == 1) m_cnt[k] = 1;
        else if (m_cnt[k] < cmax_of(k)) m_cnt[k] = m_cnt[k] + 1;
        if (drv_last[k]) begin
          m_out[k]  = crc_ref(k, q);
          m_done[k] = 1'b1;
          q.delete();
        end
      end
      if (k == 0) m_q0 = q; else m_q1 = q;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready",  k, {31'b0, o_ready[k]}, {31'b0, (!m_done[k] && !drv_clear[k])});
        chk("crc_valid", k, {31'b0, o_valid[k]}, {31'b0, m_done[k]});
        chk("crc_out",   k, o_crc[k], m_out[k]);
        chk("beat_cnt",  k, o_cnt[k], m_cnt[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called and returns at posedge+1; stalls = cycles spent waiting for ready.
  task automatic send_frame(input int k, input logic [7:0] beats[$], input bit with_last,
                            output int stalls);
    int g;
    stalls = 0;
    for (int i = 0; i < beats.size(); i++) begin
      drv_valid[k] = 1'b1;
      drv_data[k]  = beats[i];
      drv_last[k]  = with_last && (i == beats.size() - 1);
      g = 0;
      @(negedge clk);
      while (!o_ready[k] && g < 50) begin
        g++;
        @(negedge clk);
      end
      if (g >= 50) chk("accept_timeout", k, 32'd0, 32'd1);
      stalls += g;
      @(posedge clk);
      #1;
    end
    drv_valid[k] = 1'b0;
    drv_last[k]  = 1'b0;
  endtask

  initial begin
    logic [7:0] msg[$];
    logic [7:0] part[$];
    logic [7:0] one[$];
    logic [7:0] longf[$];
    int         st;

    for (int k = 0; k < 2; k++) begin
      drv_clear[k] = 1'b0; drv_valid[k] = 1'b0; drv_last[k] = 1'b0;
      drv_oready[k] = 1'b0; drv_data[k] = 8'h00;
    end
    for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 3; i++) part.push_back(msg[i]);
    one.push_back(8'h00);
    for (int i = 0; i < 20; i++) longf.push_back(8'(i * 7 + 3));

    // Pin the model to published check values.
    chk("model_crc8_check",  0, crc_ref(0, msg), 32'h00F4);
    chk("model_crc16_check", 1, crc_ref(1, msg), 32'h29B1);
    chk("model_single_zero", 0, crc_ref(0, one), 32'h0000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, {31'b0, o_ready[k]}, 32'd1);
      chk("rst_valid", k, {31'b0, o_valid[k]}, 32'd0);
      chk("rst_crc",   k, o_crc[k], 32'd0);
      chk("rst_cnt",   k, o_cnt[k], 32'd0);
    end
    cycle();

    // 1: CRC-8 of "123456789", valid one cycle after the last beat edge.
    send_frame(0, msg, 1'b1, st);
    @(negedge clk);
    chk("t1_valid_latency", 0, {31'b0, o_valid[0]}, 32'd1);
    chk("t1_crc", 0, o_crc[0], 32'h00F4);
    chk("t1_cnt", 0, o_cnt[0], 32'd9);
    cycle();
    drv_oready[0] = 1'b1;
    cycle();
    drv_oready[0] = 1'b0;

    // 2: CRC-16/CCITT held for 5 cycles with a pending beat that must wait.
    send_frame(1, msg, 1'b1, st);
    drv_valid[1] = 1'b1;
    drv_data[1]  = 8'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_hold_crc",   1, o_crc[1], 32'h29B1);
      chk("t2_hold_valid", 1, {31'b0, o_valid[1]}, 32'd1);
      chk("t2_hold_ready", 1, {31'b0, o_ready[1]}, 32'd0);
      chk("t2_hold_cnt",   1, o_cnt[1], 32'd9);
      cycle();
    end
    drv_oready[1] = 1'b1;
    cycle();
    drv_oready[1] = 1'b0;
    cycle();
    drv_valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_held_beat_taken", 1, o_cnt[1], 32'd1);
    cycle();
    drv_clear[1] = 1'b1;
    cycle();
    drv_clear[1] = 1'b0;

    // 3: back-to-back frames with out_ready high; single-beat 0x00 frame.
    drv_oready[0] = 1'b1;
    send_frame(0, msg, 1'b1, st);
    send_frame(0, one, 1'b1, st);
    chk("t3_single_stall", 0, 32'(st), 32'd1);
    @(negedge clk);
    chk("t3_crc", 0, o_crc[0], 32'h0000);
    chk("t3_cnt", 0, o_cnt[0], 32'd1);
    cycle();
    drv_oready[0] = 1'b0;
    cycle();

    // 4: clear on beat 4 with valid high, then the full frame again.
    send_frame(0, part, 1'b0, st);
    drv_valid[0] = 1'b1;
    drv_data[0]  = msg[3];
    drv_clear[0] = 1'b1;
    @(negedge clk);
    chk("t4_ready_in_clear", 0, {31'b0, o_ready[0]}, 32'd0);
    cycle();
    drv_clear[0] = 1'b0;
    drv_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4_cnt_cleared", 0, o_cnt[0], 32'd0);
    chk("t4_crc_kept",    0, o_crc[0], 32'h0000);
    cycle();
    send_frame(0, msg, 1'b1, st);
    @(negedge clk);
    chk("t4_crc", 0, o_crc[0], 32'h00F4);
    chk("t4_cnt", 0, o_cnt[0], 32'd9);
    cycle();
    drv_oready[0] = 1'b1;
    cycle();
    drv_oready[0] = 1'b0;

    // 5: asynchronous reset in mid-cycle during ACCUM.
    send_frame(0, part, 1'b0, st);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 0, {31'b0, o_valid[0]}, 32'd0);
    chk("t5_async_cnt",   0, o_cnt[0], 32'd0);
    chk("t5_async_crc",   0, o_crc[0], 32'd0);
    rst = 1'b0;
    cycle();
    send_frame(0, msg, 1'b1, st);
    @(negedge clk);
    chk("t5_crc", 0, o_crc[0], 32'h00F4);
    chk("t5_cnt", 0, o_cnt[0], 32'd9);
    cycle();
    drv_oready[0] = 1'b1;
    cycle();
    drv_oready[0] = 1'b0;

    // 6: 20-beat frame on the 4-bit counter saturates at 15.
    send_frame(0, longf, 1'b1, st);
    @(negedge clk);
    chk("t6_cnt_sat", 0, o_cnt[0], 32'd15);
    chk("t6_crc",     0, o_crc[0], crc_ref(0, longf));
    cycle();
    drv_oready[0] = 1'b1;
    cycle();
    drv_oready[0] = 1'b0;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
